pc_redirect_ctrl: RTL

- Control-flow sequencer between the EX-stage branch resolver and the fetch/decode pipeline registers.
- Takes each resolved branch/jump outcome (taken flag, target) and the load-use stall request. Drives PC write-enable, next-PC select, the redirect target and the IF/ID and ID/EX flush/enable controls.
- After a taken redirect, enforces a parameterised bubble window in which EX results are ignored.

---
 rtl/pc_redirect_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: control-flow sequencer between the EX branch resolver and
// the fetch/decode pipeline registers. It drives PC write/select, the redirect
// target, and the IF/ID / ID/EX enable and flush controls. A taken redirect is
// followed by a bubble window of FLUSH_CYC cycles in total.
// Optional build macro PC_REDIRECT_PERF_EN adds saturating performance counters
// (ctrl_cnt, taken_cnt, stall_cnt).
module pc_redirect_ctrl #(
   parameter int unsigned PC_W      = 9,
   parameter int unsigned FLUSH_CYC = 2,
   parameter int unsigned CNT_W     = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ex_valid,
   input  logic            ex_is_ctrl,
   input  logic            ex_pcsel,
   input  logic [31:0]     ex_brpc,
   input  logic            hz_stall,
   output logic            pc_we,
   output logic            pc_sel,
   output logic [PC_W-1:0] pc_redirect,
   output logic            if_id_we,
   output logic            if_id_flush,
   output logic            id_ex_flush,
   output logic            busy,
   output logic            misalign_err
`ifdef PC_REDIRECT_PERF_EN
   ,
   output logic [CNT_W-1:0] ctrl_cnt,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   localparam int unsigned FCNT_W = 4;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [FCNT_W-1:0] flush_cnt;
   logic [FCNT_W-1:0] flush_cnt_nxt;
   logic              take;

   // Upper target bits are dropped on purpose; fold them into a sink.
   logic unused_brpc_hi;
   assign unused_brpc_hi = ^ex_brpc[31:PC_W];

   // State and bubble-window counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   // Next-state and combinational control decode (zero-latency redirect).
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      pc_we         = 1'b0;
      pc_sel        = 1'b0;
      pc_redirect   = '0;
      if_id_we      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      busy          = 1'b0;
      misalign_err  = 1'b0;
      take          = (state == RUN) & ex_valid & ex_is_ctrl & ex_pcsel;

      if (!reset) begin
         pc_redirect = {ex_brpc[PC_W-1:2], 2'b00};
         case (state)
            RUN: begin
               if (take) begin
                  pc_we        = 1'b1;
                  pc_sel       = 1'b1;
                  if_id_we     = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_flush  = 1'b1;
                  misalign_err = |ex_brpc[1:0];
                  if (FLUSH_CYC > 1) begin
                     state_nxt     = FLUSH;
                     flush_cnt_nxt = FCNT_W'(FLUSH_CYC - 1);
                  end
               end else if (hz_stall) begin
                  pc_we       = 1'b0;
                  if_id_we    = 1'b0;
                  if_id_flush = 1'b0;
                  id_ex_flush = 1'b1;
               end else begin
                  pc_we       = 1'b1;
                  if_id_we    = 1'b1;
                  if_id_flush = 1'b0;
                  id_ex_flush = 1'b0;
               end
            end
            FLUSH: begin
               busy          = 1'b1;
               pc_we         = 1'b1;
               if_id_we      = 1'b1;
               if_id_flush   = 1'b1;
               id_ex_flush   = 1'b1;
               flush_cnt_nxt = flush_cnt - FCNT_W'(1);
               if (flush_cnt <= FCNT_W'(1)) begin
                  state_nxt     = RUN;
                  flush_cnt_nxt = '0;
               end
            end
            default: begin
               state_nxt     = RUN;
               flush_cnt_nxt = '0;
            end
         endcase
      end
   end

`ifdef PC_REDIRECT_PERF_EN
   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_cnt  <= '0;
         taken_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if ((state == RUN) && ex_valid && ex_is_ctrl && (ctrl_cnt != '1))
            ctrl_cnt <= ctrl_cnt + CNT_W'(1);
         if (take && (taken_cnt != '1))
            taken_cnt <= taken_cnt + CNT_W'(1);
         if ((state == RUN) && !take && hz_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
